// File: rtl/display_secuenciador_if.sv
// Request handshake between the application logic and the display sequencer.
// The master drives offers and cancel requests; the slave answers with ready.
interface display_secuenciador_if;
   logic       req_valid;
   logic [7:0] req_valor;
   logic       req_ready;
   logic       cancelar;

   modport master (output req_valid, output req_valor, output cancelar, input req_ready);
   modport slave  (input req_valid, input req_valor, input cancelar, output req_ready);
endinterface

// File: rtl/display_secuenciador.sv
// Buffers 8-bit values in a small FIFO and plays each one on a two-digit display
// using the start / mid / end pulse protocol, with an optional blank pause.
module display_secuenciador #(
   parameter int unsigned CICLOS_DIGITO = 50_000_000,
   parameter int unsigned CICLOS_PAUSA  = 25_000_000,
   parameter int unsigned PROFUNDIDAD   = 4
) (
   input  logic                               clk,
   input  logic                               reset_n,
   display_secuenciador_if.slave              req,
   output logic                               Displayiniciar,
   output logic                               PulsoMitad,
   output logic                               PulsoFin,
   output logic [15:0]                        DisplayValor,
   output logic                               ocupado,
   output logic [$clog2(PROFUNDIDAD+1)-1:0]   nivel
);
   localparam int unsigned   PW          = $clog2(PROFUNDIDAD);
   localparam int unsigned   NW          = $clog2(PROFUNDIDAD + 1);
   localparam logic [NW-1:0] NIVEL_LLENO = NW'(PROFUNDIDAD);
   localparam logic [31:0]   FIN_DIGITO  = 32'(CICLOS_DIGITO - 1);
   localparam logic [31:0]   FIN_PAUSA   = 32'(CICLOS_PAUSA - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DIG1  = 2'd1;
   localparam logic [1:0] DIG2  = 2'd2;
   localparam logic [1:0] PAUSA = 2'd3;

   logic [7:0]    mem_q [PROFUNDIDAD];
   logic [7:0]    mem_d [PROFUNDIDAD];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [NW-1:0] nivel_q, nivel_d;
   logic [1:0]    estado_q, estado_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [15:0]   valor_q, valor_d;
   logic          ini_q, ini_d, mit_q, mit_d, fin_q, fin_d;
   logic          push, pop;

   assign req.req_ready = (nivel_q != NIVEL_LLENO) && !req.cancelar;
   assign push          = req.req_valid && req.req_ready;
   // Pops only happen from IDLE, and cancel suppresses them.
   assign pop           = (estado_q == IDLE) && (nivel_q != '0) && !req.cancelar;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      nivel_d = nivel_q;
      if (req.cancelar) begin
         wr_d    = '0;
         rd_d    = '0;
         nivel_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = req.req_valor;
            wr_d        = wr_q + PW'(1);
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
         nivel_d = nivel_q + NW'(push) - NW'(pop);
      end
   end

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      valor_d  = valor_q;
      ini_d    = 1'b0;
      mit_d    = 1'b0;
      fin_d    = 1'b0;
      unique case (estado_q)
         IDLE: begin
            if (pop) begin
               valor_d  = {8'h00, mem_q[rd_q]};
               ini_d    = 1'b1;
               cnt_d    = '0;
               estado_d = DIG1;
            end
         end
         DIG1: begin
            if (req.cancelar) begin
               fin_d    = 1'b1;
               cnt_d    = '0;
               estado_d = IDLE;
            end else if (cnt_q == FIN_DIGITO) begin
               mit_d    = 1'b1;
               cnt_d    = '0;
               estado_d = DIG2;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DIG2: begin
            if (req.cancelar) begin
               fin_d    = 1'b1;
               cnt_d    = '0;
               estado_d = IDLE;
            end else if (cnt_q == FIN_DIGITO) begin
               fin_d    = 1'b1;
               cnt_d    = '0;
               estado_d = (CICLOS_PAUSA == 0) ? IDLE : PAUSA;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         PAUSA: begin
            if (req.cancelar || (cnt_q == FIN_PAUSA)) begin
               cnt_d    = '0;
               estado_d = IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            cnt_d    = '0;
            estado_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PROFUNDIDAD; i++) begin
            mem_q[i] <= '0;
         end
         wr_q     <= '0;
         rd_q     <= '0;
         nivel_q  <= '0;
         estado_q <= IDLE;
         cnt_q    <= '0;
         valor_q  <= '0;
         ini_q    <= 1'b0;
         mit_q    <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         nivel_q  <= nivel_d;
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         valor_q  <= valor_d;
         ini_q    <= ini_d;
         mit_q    <= mit_d;
         fin_q    <= fin_d;
      end
   end

   assign Displayiniciar = ini_q;
   assign PulsoMitad     = mit_q;
   assign PulsoFin       = fin_q;
   assign DisplayValor   = valor_q;
   assign ocupado        = (estado_q != IDLE);
   assign nivel          = nivel_q;
endmodule

// File: tb/tb_display_secuenciador.sv
// Directed and random checks of display_secuenciador against a timeline model:
// each display is a start edge plus fixed offsets for the mid, end and idle points.
module tb_display_secuenciador;
   localparam int CD = 4;
   localparam int CP = 2;
   localparam int P  = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   display_secuenciador_if bus ();
   display_secuenciador_if bus0 ();

   logic        ini, mid, fin, ocu;
   logic [15:0] val;
   logic [2:0]  niv;
   logic        ini0, mid0, fin0, ocu0;
   logic [15:0] val0;
   logic [2:0]  niv0;

   display_secuenciador #(.CICLOS_DIGITO(CD), .CICLOS_PAUSA(CP), .PROFUNDIDAD(P)) dut (
      .clk(clk), .reset_n(reset_n), .req(bus),
      .Displayiniciar(ini), .PulsoMitad(mid), .PulsoFin(fin),
      .DisplayValor(val), .ocupado(ocu), .nivel(niv)
   );

   display_secuenciador #(.CICLOS_DIGITO(CD), .CICLOS_PAUSA(0), .PROFUNDIDAD(P)) dut0 (
      .clk(clk), .reset_n(reset_n), .req(bus0),
      .Displayiniciar(ini0), .PulsoMitad(mid0), .PulsoFin(fin0),
      .DisplayValor(val0), .ocupado(ocu0), .nivel(niv0)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: queue contents, whether a display is running, edges since its start.
   logic [7:0] mq[$];
   bit         m_busy;
   int         m_t;
   bit         e_ini, e_mid, e_fin;
   logic [7:0] e_val;

   int         cyc = 0;
   bit         last_acc;
   int         ini_cyc[$];
   logic [7:0] val_seq[$];
   int         mid_c, fin_c, fall_c;
   bit         prev_ocu;
   int         ini0_cyc[$];
   int         fin0_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy   = 1'b0;
      m_t      = 0;
      e_ini    = 1'b0;
      e_mid    = 1'b0;
      e_fin    = 1'b0;
      e_val    = 8'h00;
      prev_ocu = 1'b0;
   endtask

   task automatic step();
      logic       v, c;
      logic [7:0] d;
      #1;
      chk("req_ready", bus.req_ready, (mq.size() < P) && !bus.cancelar);
      v = bus.req_valid;
      c = bus.cancelar;
      d = bus.req_valor;
      @(posedge clk);
      cyc++;
      last_acc = v && (mq.size() < P) && !c;
      e_ini = 1'b0;
      e_mid = 1'b0;
      e_fin = 1'b0;
      if (c) begin
         if (m_busy && m_t < 2 * CD) e_fin = 1'b1;
         m_busy = 1'b0;
         mq.delete();
      end else begin
         if (m_busy) begin
            m_t++;
            if (m_t == CD) e_mid = 1'b1;
            if (m_t == 2 * CD) e_fin = 1'b1;
            if (m_t == 2 * CD + CP) m_busy = 1'b0;
         end else if (mq.size() > 0) begin
            e_val  = mq.pop_front();
            e_ini  = 1'b1;
            m_busy = 1'b1;
            m_t    = 0;
         end
         if (last_acc) mq.push_back(d);
      end
      #1;
      chk("Displayiniciar", ini, e_ini);
      chk("PulsoMitad", mid, e_mid);
      chk("PulsoFin", fin, e_fin);
      chk("DisplayValor", val, {8'h00, e_val});
      chk("ocupado", ocu, m_busy);
      chk("nivel", niv, mq.size());
      chk("un_pulso", $countones({ini, mid, fin}) <= 1, 1);
      if (ini) begin
         ini_cyc.push_back(cyc);
         val_seq.push_back(val[7:0]);
      end
      if (mid) mid_c = cyc;
      if (fin) fin_c = cyc;
      if (prev_ocu && !ocu) fall_c = cyc;
      prev_ocu = ocu;
      if (ini0) ini0_cyc.push_back(cyc);
      if (fin0) begin
         fin0_n++;
         chk("p0_ocupado_en_fin", ocu0, 0);
      end
   endtask

   task automatic push_val(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_valor = d;
      for (int i = 0; i < 100 && !ok; i++) begin
         step();
         ok = last_acc;
      end
      bus.req_valid = 1'b0;
      chk("push_aceptado", ok, 1);
   endtask

   task automatic single_timing(input string tag, input logic [7:0] d);
      int k;
      ini_cyc.delete();
      push_val(d);
      k = cyc;
      repeat (14) step();
      chk({tag, "_n_ini"}, ini_cyc.size(), 1);
      chk({tag, "_ini"}, (ini_cyc.size() > 0) ? ini_cyc[0] : -1, k + 1);
      chk({tag, "_valor"}, val, {8'h00, d});
      chk({tag, "_mitad"}, mid_c, k + 5);
      chk({tag, "_fin"}, fin_c, k + 9);
      chk({tag, "_ocupado_baja"}, fall_c, k + 11);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_seq [6];
      bit         got;
      int         acc55;
      exp_seq = '{8'h99, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      bus.req_valid  = 1'b0;
      bus.req_valor  = 8'h00;
      bus.cancelar   = 1'b0;
      bus0.req_valid = 1'b0;
      bus0.req_valor = 8'h00;
      bus0.cancelar  = 1'b0;
      fin0_n = 0;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ini", ini, 0);
      chk("rst_fin", fin, 0);
      chk("rst_valor", val, 16'h0000);
      chk("rst_ocupado", ocu, 0);
      chk("rst_nivel", niv, 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();

      // Single value timing.
      single_timing("c1", 8'h3A);

      // Full FIFO with a held offer.
      ini_cyc.delete();
      val_seq.delete();
      push_val(8'h99);
      push_val(8'h11);
      push_val(8'h22);
      push_val(8'h33);
      push_val(8'h44);
      chk("c2_nivel_lleno", niv, 4);
      bus.req_valid = 1'b1;
      bus.req_valor = 8'h55;
      #1;
      chk("c2_ready_lleno", bus.req_ready, 0);
      push_val(8'h55);
      acc55 = cyc;
      repeat (80) step();
      chk("c2_n_ini", ini_cyc.size(), 6);
      for (int i = 1; i < ini_cyc.size(); i++) chk("c2_espaciado", ini_cyc[i] - ini_cyc[i-1], 11);
      for (int i = 0; i < 6 && i < val_seq.size(); i++) chk("c2_orden", val_seq[i], exp_seq[i]);
      chk("c2_acepta_55", acc55, (ini_cyc.size() > 1) ? ini_cyc[1] + 1 : -1);

      // Cancel two edges after the mid pulse.
      push_val(8'hA1);
      push_val(8'hA2);
      push_val(8'hA3);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         got = mid;
      end
      chk("c3_mitad_vista", got, 1);
      step();
      bus.cancelar = 1'b1;
      step();
      bus.cancelar = 1'b0;
      chk("c3_fin", fin, 1);
      chk("c3_nivel", niv, 0);
      chk("c3_ocupado", ocu, 0);
      ini_cyc.delete();
      repeat (30) step();
      chk("c3_sin_ini", ini_cyc.size(), 0);

      // Cancel and push together while idle and empty.
      bus.cancelar  = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_valor = 8'h5C;
      #1;
      chk("c4_ready", bus.req_ready, 0);
      step();
      bus.cancelar  = 1'b0;
      bus.req_valid = 1'b0;
      chk("c4_nivel", niv, 0);
      repeat (3) step();
      chk("c4_sin_ini", ini_cyc.size(), 0);

      // Zero-pause build: two values back to back.
      bus0.req_valid = 1'b1;
      bus0.req_valor = 8'h12;
      step();
      bus0.req_valor = 8'h34;
      step();
      bus0.req_valid = 1'b0;
      repeat (30) step();
      chk("c5_n_ini", ini0_cyc.size(), 2);
      chk("c5_espaciado", (ini0_cyc.size() > 1) ? ini0_cyc[1] - ini0_cyc[0] : -1, 9);
      chk("c5_n_fin", fin0_n, 2);
      chk("c5_valor", val0, 16'h0034);

      // Random traffic with held offers and occasional cancels.
      last_acc = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (!bus.req_valid || last_acc) begin
            bus.req_valid = ($urandom_range(0, 2) != 0);
            bus.req_valor = 8'($urandom);
         end
         bus.cancelar = ($urandom_range(0, 39) == 0);
         step();
      end
      bus.req_valid = 1'b0;
      bus.cancelar  = 1'b1;
      step();
      bus.cancelar = 1'b0;
      repeat (3) step();

      // Reset in the middle of the first digit.
      push_val(8'h77);
      push_val(8'h78);
      step();
      #3 reset_n = 1'b0;
      #1;
      chk("c6_ini", ini, 0);
      chk("c6_mitad", mid, 0);
      chk("c6_fin", fin, 0);
      chk("c6_valor", val, 16'h0000);
      chk("c6_ocupado", ocu, 0);
      chk("c6_nivel", niv, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      single_timing("c6b", 8'hC5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
